// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared occupancy encodings and constants for the fifo_rd_ctrl read-side controller.
package fifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  localparam int unsigned CNT_W = 16;

  // Packet index width: ceil(log2(n)), never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Buffer-side and stream-side signals of fifo_rd_ctrl; Count_out exists only with FIFO_RD_CTRL_CNT_EN.
interface fifo_rd_ctrl_if
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = 8
);
  logic            Empty;
  logic [SIZE-1:0] Data_in;
  logic            Rd_En;
  logic [SIZE-1:0] Data_out;
  logic            Valid_out;
  logic            Ready_in;
  logic            Last_out;
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [CNT_W-1:0] Count_out;
`endif

  modport master (
    input  Empty, Data_in, Ready_in,
    output Rd_En, Data_out, Valid_out, Last_out
`ifdef FIFO_RD_CTRL_CNT_EN
    , output Count_out
`endif
  );

  modport slave (
    output Empty, Data_in, Ready_in,
    input  Rd_En, Data_out, Valid_out, Last_out
`ifdef FIFO_RD_CTRL_CNT_EN
    , input Count_out
`endif
  );

endinterface

// File: rtl/fifo_rd_ctrl_skid_buf2.sv
// Two-entry shift buffer: entry 0 is the head, occupancy tracked as EMPTY/ONE/FULL.
module skid_buf2
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] dout,
  output occ_state_t      occ
);

  logic [SIZE-1:0] mem0;
  logic [SIZE-1:0] mem1;

  // Simultaneous push+pop shifts and refills the tail in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= EMPTY;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case (occ)
        EMPTY: begin
          if (push) begin
            mem0 <= din;
            occ  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            mem0 <= din;
          end else if (push) begin
            mem1 <= din;
            occ  <= FULL;
          end else if (pop) begin
            occ  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            mem0 <= mem1;
            if (push) mem1 <= din;
            else      occ  <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

  assign dout = mem0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO drain with credit-based issue, skid absorption and packet framing.
// Optional pop counter Count_out is built when FIFO_RD_CTRL_CNT_EN is defined.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic           Rd_clk,
  input  logic           RST_n,
  fifo_rd_ctrl_if.master bus
);

  localparam int unsigned     PKT_W    = idx_width(PKT_LEN);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);

  occ_state_t       occ;
  logic             inflight;
  logic             armed;
  logic [PKT_W-1:0] pkt_idx;
  logic             valid_c;
  logic             pop_c;
  logic             rd_en_c;
  logic [2:0]       credit_c;

  assign valid_c  = (occ != EMPTY);
  assign pop_c    = valid_c & bus.Ready_in;
  assign credit_c = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_c};
  // armed keeps Rd_En low until the first clock edge after reset release.
  assign rd_en_c  = armed & ~bus.Empty & (credit_c < 3'd2);

  assign bus.Rd_En     = rd_en_c;
  assign bus.Valid_out = valid_c;
  assign bus.Last_out  = valid_c & (pkt_idx == PKT_LAST);

  skid_buf2 #(.SIZE(SIZE)) u_skid (
    .clk   (Rd_clk),
    .rst_n (RST_n),
    .push  (inflight),
    .pop   (pop_c),
    .din   (bus.Data_in),
    .dout  (bus.Data_out),
    .occ   (occ)
  );

  always_ff @(posedge Rd_clk or negedge RST_n) begin
    if (!RST_n) begin
      armed    <= 1'b0;
      inflight <= 1'b0;
      pkt_idx  <= '0;
    end else begin
      armed    <= 1'b1;
      inflight <= rd_en_c;
      if (pop_c) begin
        pkt_idx <= (pkt_idx == PKT_LAST) ? '0 : pkt_idx + PKT_W'(1);
      end
    end
  end

`ifdef FIFO_RD_CTRL_CNT_EN
  logic [CNT_W-1:0] count;

  always_ff @(posedge Rd_clk or negedge RST_n) begin
    if (!RST_n)     count <= '0;
    else if (pop_c) count <= count + CNT_W'(1);
  end

  assign bus.Count_out = count;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed-vector bench for fifo_rd_ctrl with a behavioural 1-cycle-latency buffer model.
module tb_fifo_rd_ctrl;
  import fifo_rd_ctrl_pkg::*;

  localparam int unsigned SIZE    = 8;
  localparam int unsigned PKT_LEN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.SIZE(SIZE)) bus ();

  fifo_rd_ctrl #(.SIZE(SIZE), .PKT_LEN(PKT_LEN)) dut (
    .Rd_clk (clk),
    .RST_n  (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffer model: synchronous read, data appears the cycle after Rd_En.
  logic [SIZE-1:0] mem [0:2047];
  int unsigned     wr_cnt = 0;
  int unsigned     rd_ptr = 0;
  logic            gap    = 1'b0;
  logic            flush  = 1'b0;
  int unsigned     cyc    = 0;

  assign bus.Empty = gap || (rd_ptr == wr_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_cnt;
    end else if (bus.Rd_En && !bus.Empty) begin
      bus.Data_in <= mem[11'(rd_ptr)];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Monitor: logs reads and pops, counts protocol violations.
  logic [SIZE-1:0] pop_d [$];
  logic            pop_l [$];
  int unsigned     pop_c [$];
  int unsigned     rd_c  [$];
  int              viol_cnt  = 0;
  int              hold_viol = 0;
  int              occ_max   = 0;
  logic            prev_stall = 1'b0;
  logic [SIZE-1:0] prev_d = '0;
  logic            prev_l = 1'b0;

  always @(negedge clk) begin
    if (bus.Rd_En) rd_c.push_back(cyc);
    if (bus.Rd_En && bus.Empty) viol_cnt++;
    if (int'(dut.u_skid.occ) > occ_max) occ_max = int'(dut.u_skid.occ);
    if (bus.Valid_out && bus.Ready_in) begin
      pop_d.push_back(bus.Data_out);
      pop_l.push_back(bus.Last_out);
      pop_c.push_back(cyc);
    end
    if (prev_stall && rst_n &&
        (!bus.Valid_out || bus.Data_out != prev_d || bus.Last_out != prev_l)) hold_viol++;
    prev_stall = rst_n && bus.Valid_out && !bus.Ready_in;
    prev_d     = bus.Data_out;
    prev_l     = bus.Last_out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [SIZE-1:0] w);
    mem[11'(wr_cnt)] = w;
    wr_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    gap   = 1'b0;
    tick(2);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(1);
  endtask

  // Checks n pops starting at base against words first..first+n-1, Last on every 4th.
  task automatic chk_seq(input string tag, input int base, input int n, input int first);
    chk({tag, "_npop"}, 32'(pop_d.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < pop_d.size()) begin
        chk({tag, "_data"}, 32'(pop_d[base + i]), 32'(first + i));
        chk({tag, "_last"}, 32'(pop_l[base + i]), 32'((i % 4) == 3));
      end
    end
  endtask

  int          base_pop;
  int          base_rd;
  logic [7:0]  rnd_w [0:999];
  int          pushed;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Ready_in = 1'b0;
    bus.Data_in  = '0;

    // Reset held with data available.
    push_word(8'h11);
    push_word(8'h12);
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", 32'(bus.Rd_En), 32'd0);
      chk("rst_valid", 32'(bus.Valid_out), 32'd0);
      chk("rst_last",  32'(bus.Last_out), 32'd0);
      chk("rst_data",  32'(bus.Data_out), 32'd0);
`ifdef FIFO_RD_CTRL_CNT_EN
      chk("rst_count", 32'(bus.Count_out), 32'd0);
`endif
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rd_en_pre_edge", 32'(bus.Rd_En), 32'd0);
    @(negedge clk);
    chk("rel_rd_en_first", 32'(bus.Rd_En), 32'd1);

    // Streaming 0x01..0x08.
    do_reset();
    bus.Ready_in = 1'b1;
    base_pop = pop_d.size();
    base_rd  = rd_c.size();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    tick(14);
    chk_seq("st", base_pop, 8, 1);
    chk("st_nrd", 32'(rd_c.size() - base_rd), 32'd8);
    if (pop_c.size() >= base_pop + 8 && rd_c.size() > base_rd) begin
      chk("st_latency", pop_c[base_pop] - rd_c[base_rd], 32'd2);
      chk("st_contig",  pop_c[base_pop + 7] - pop_c[base_pop], 32'd7);
    end
`ifdef FIFO_RD_CTRL_CNT_EN
    chk("st_count", 32'(bus.Count_out), 32'd8);
`endif

    // Backpressure: 10 stalled cycles with 5 words ready.
    do_reset();
    bus.Ready_in = 1'b0;
    base_pop = pop_d.size();
    base_rd  = rd_c.size();
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    tick(10);
    @(negedge clk);
    chk("bp_nrd",  32'(rd_c.size() - base_rd), 32'd2);
    chk("bp_valid", 32'(bus.Valid_out), 32'd1);
    chk("bp_held", 32'(bus.Data_out), 32'h01);
    chk("bp_rd_en_low", 32'(bus.Rd_En), 32'd0);
    tick(1);
    bus.Ready_in = 1'b1;
    tick(12);
    chk_seq("bp", base_pop, 5, 1);
    chk("bp_hold_rule", 32'(hold_viol), 32'd0);

    // Empty gap mid-packet.
    do_reset();
    bus.Ready_in = 1'b1;
    base_pop = pop_d.size();
    push_word(8'h21);
    push_word(8'h22);
    tick(2);
    gap = 1'b1;
    push_word(8'h23);
    push_word(8'h24);
    base_rd = rd_c.size();
    tick(5);
    chk("gap_no_rd", 32'(rd_c.size() - base_rd), 32'd0);
    gap = 1'b0;
    tick(8);
    chk_seq("gap", base_pop, 4, 32'h21);

    // Random Ready_in and Empty over 1000 words.
    do_reset();
    base_pop = pop_d.size();
    pushed   = 0;
    for (int c = 0; c < 20000 && (pop_d.size() - base_pop) < 1000; c++) begin
      bus.Ready_in = 1'($urandom_range(0, 1));
      gap          = ($urandom_range(0, 3) == 0);
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        rnd_w[pushed] = 8'($urandom);
        push_word(rnd_w[pushed]);
        pushed++;
      end
      tick(1);
    end
    gap = 1'b0;
    bus.Ready_in = 1'b1;
    chk("rnd_npop", 32'(pop_d.size() - base_pop), 32'd1000);
    for (int i = 0; i < 1000; i++) begin
      if (base_pop + i < pop_d.size()) begin
        chk("rnd_data", 32'(pop_d[base_pop + i]), 32'(rnd_w[i]));
        chk("rnd_last", 32'(pop_l[base_pop + i]), 32'((i % 4) == 3));
      end
    end
    chk("rnd_rd_while_empty", 32'(viol_cnt), 32'd0);
    chk("rnd_occ_le_2", 32'(occ_max <= 2), 32'd1);
    chk("rnd_hold_rule", 32'(hold_viol), 32'd0);

    // Reset mid-stream with a word buffered and one in flight.
    do_reset();
    bus.Ready_in = 1'b1;
    base_pop = pop_d.size();
    for (int i = 0; i < 6; i++) push_word(8'(8'h31 + i));
    tick(5);
    chk("mr_pre_pops", 32'(pop_d.size() - base_pop), 32'd3);
    chk("mr_pre_valid", 32'(bus.Valid_out), 32'd1);
    rst_n = 1'b0;
    flush = 1'b1;
    #1;
    chk("mr_valid_drop", 32'(bus.Valid_out), 32'd0);
    chk("mr_rd_en_drop", 32'(bus.Rd_En), 32'd0);
    chk("mr_data_clear", 32'(bus.Data_out), 32'd0);
    tick(2);
    flush = 1'b0;
    rst_n = 1'b1;
    base_pop = pop_d.size();
    for (int i = 0; i < 4; i++) push_word(8'(8'h41 + i));
    tick(14);
    chk_seq("mr", base_pop, 4, 32'h41);
`ifdef FIFO_RD_CTRL_CNT_EN
    chk("mr_count", 32'(bus.Count_out), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
